// File: rtl/puzzle_defs_pkg.sv
// Shared geometry, colour constants and drawer state encoding for the puzzle display path.
package puzzle_defs;

    // Default tile and coordinate geometry; the screen is a 2x2 grid of tiles.
    localparam int TILE_W_DEF   = 80;
    localparam int TILE_H_DEF   = 60;
    localparam int X_W_DEF      = 8;
    localparam int Y_W_DEF      = 7;
    localparam int COLOUR_W_DEF = 3;
    localparam int SCREEN_W     = 2 * TILE_W_DEF;
    localparam int SCREEN_H     = 2 * TILE_H_DEF;

    // Colours are {R,G,B}.
    localparam logic [2:0] BLACK      = 3'b000;
    localparam logic [2:0] WHITE      = 3'b111;
    localparam logic [2:0] WIN_COLOUR = 3'b010;

    // Interior colour per tile id, index 0 in the low slice.
    localparam logic [3:0][2:0] TILE_COLOUR = {3'b110, 3'b001, 3'b010, 3'b100};

    // Drawer FSM encoding, also visible on the debug state port.
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_TILE = 3'd1;
    localparam logic [2:0] ST_FILL = 3'd2;
    localparam logic [2:0] ST_DONE = 3'd3;
    localparam logic [2:0] ST_HOLD = 3'd4;

    // Interior colour lookup for a tile id.
    function automatic logic [2:0] tile_colour(input logic [1:0] id);
        return TILE_COLOUR[id];
    endfunction

endpackage

// File: rtl/raster_scan.sv
// Row-major scan counters: cx runs 0..i_w_last inside cy 0..i_h_last, both wrap to 0.
module raster_scan #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_start,
    input  logic           i_en,
    input  logic [X_W-1:0] i_w_last,
    input  logic [Y_W-1:0] i_h_last,
    output logic [X_W-1:0] o_cx,
    output logic [Y_W-1:0] o_cy,
    output logic           o_last
);

    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic           w_x_end;
    logic           w_y_end;

    assign w_x_end = (r_cx == i_w_last);
    assign w_y_end = (r_cy == i_h_last);
    assign o_cx    = r_cx;
    assign o_cy    = r_cy;
    assign o_last  = w_x_end && w_y_end;

    // Zero on start, otherwise step one pixel per enabled cycle with wrap at the limits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_start) begin
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_en) begin
            if (w_x_end) begin
                r_cx <= '0;
                r_cy <= w_y_end ? '0 : r_cy + Y_W'(1);
            end else begin
                r_cx <= r_cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/tile_drawer.sv
// Rasterises one grid tile or a full-screen fill into the VGA adapter, one pixel per cycle.
// Handshake: a request is a level on draw/clear/win sampled only in IDLE; busy rises the
// cycle after acceptance, plot marks each valid pixel, done pulses once the cycle after
// the final plot, and a request still held afterwards is not redrawn until it drops.
module tile_drawer
    import puzzle_defs::*;
#(
    parameter int TILE_W   = TILE_W_DEF,
    parameter int TILE_H   = TILE_H_DEF,
    parameter int X_W      = X_W_DEF,
    parameter int Y_W      = Y_W_DEF,
    parameter int COLOUR_W = COLOUR_W_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                draw,
    input  logic                clear,
    input  logic                win,
    input  logic [1:0]          tile_id,
    input  logic [1:0]          location,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                busy,
    output logic                done,
    output logic [2:0]          dbg_state
);

    localparam int SCR_W = 2 * TILE_W;
    localparam int SCR_H = 2 * TILE_H;

    logic [2:0]          r_state;
    logic [1:0]          r_id;
    logic [1:0]          r_loc;
    logic [COLOUR_W-1:0] r_fill_colour;
    logic                r_win_block;

    logic                w_win_req;
    logic                w_accept;
    logic                w_scan_en;
    logic                w_is_fill;
    logic [X_W-1:0]      w_w_last;
    logic [Y_W-1:0]      w_h_last;
    logic [X_W-1:0]      w_cx;
    logic [Y_W-1:0]      w_cy;
    logic                w_last;
    logic [X_W-1:0]      w_ox;
    logic [Y_W-1:0]      w_oy;
    logic                w_border;
    logic [COLOUR_W-1:0] w_pix_colour;

    assign dbg_state = r_state;

    // A win already served stays blocked until the win input drops.
    assign w_win_req = win && !r_win_block;
    assign w_accept  = (r_state == ST_IDLE) && (clear || draw || w_win_req);
    assign w_is_fill = (r_state == ST_FILL);
    assign w_scan_en = (r_state == ST_TILE) || w_is_fill;

    assign w_w_last = w_is_fill ? X_W'(SCR_W - 1) : X_W'(TILE_W - 1);
    assign w_h_last = w_is_fill ? Y_W'(SCR_H - 1) : Y_W'(TILE_H - 1);

    raster_scan #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .i_clk    (Clock),
        .i_rst_n  (Reset),
        .i_start  (w_accept),
        .i_en     (w_scan_en),
        .i_w_last (w_w_last),
        .i_h_last (w_h_last),
        .o_cx     (w_cx),
        .o_cy     (w_cy),
        .o_last   (w_last)
    );

    // Tile origin from the latched slot; fills always start at the screen origin.
    assign w_ox = (!w_is_fill && r_loc[0]) ? X_W'(TILE_W) : '0;
    assign w_oy = (!w_is_fill && r_loc[1]) ? Y_W'(TILE_H) : '0;

    assign w_border = (w_cx == '0) || (w_cx == X_W'(TILE_W - 1)) ||
                      (w_cy == '0) || (w_cy == Y_W'(TILE_H - 1));

    // Colour mux: fill colour, tile border, or tile interior by latched id.
    always_comb begin
        w_pix_colour = r_fill_colour;
        if (!w_is_fill) begin
            w_pix_colour = w_border ? COLOUR_W'(WHITE) : COLOUR_W'(tile_colour(r_id));
        end
    end

    // Track whether the current high level on win has already produced a fill.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_win_block <= 1'b0;
        end else if (!win) begin
            r_win_block <= 1'b0;
        end else if (w_accept && !clear && !draw) begin
            r_win_block <= 1'b1;
        end
    end

    // Request FSM with registered pixel outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state       <= ST_IDLE;
            r_id          <= '0;
            r_loc         <= '0;
            r_fill_colour <= '0;
            x             <= '0;
            y             <= '0;
            colour        <= '0;
            plot          <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    plot <= 1'b0;
                    done <= 1'b0;
                    if (w_accept) begin
                        r_id  <= tile_id;
                        r_loc <= location;
                        busy  <= 1'b1;
                        if (clear) begin
                            r_fill_colour <= COLOUR_W'(BLACK);
                            r_state       <= ST_FILL;
                        end else if (draw) begin
                            r_state       <= ST_TILE;
                        end else begin
                            r_fill_colour <= COLOUR_W'(WIN_COLOUR);
                            r_state       <= ST_FILL;
                        end
                    end
                end
                ST_TILE, ST_FILL: begin
                    plot   <= 1'b1;
                    x      <= w_ox + w_cx;
                    y      <= w_oy + w_cy;
                    colour <= w_pix_colour;
                    if (w_last) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= ST_HOLD;
                end
                ST_HOLD: begin
                    done <= 1'b0;
                    if (!draw && !clear) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    plot    <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_drawer.sv
// Directed bench for tile_drawer: a pixel-list model of each request feeds an expected
// queue that a per-cycle monitor drains, plus literal pins on selected pixels.
module tb_tile_drawer;

    logic       Clock;
    logic       Reset;
    logic       draw;
    logic       clear;
    logic       win;
    logic [1:0] tile_id;
    logic [1:0] location;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;
    logic [2:0] dbg_state;

    tile_drawer dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .draw      (draw),
        .clear     (clear),
        .win       (win),
        .tile_id   (tile_id),
        .location  (location),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_raw    = 0;
    int n_done   = 0;
    int op_idx   = 0;
    bit mon_en   = 0;
    bit want_done = 0;
    logic [17:0] exp_q[$];
    logic [17:0] cap_first, cap_81, cap_last, got, e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else n_pass++;
    endtask

    function automatic logic [17:0] pix(input int px, input int py, input int pc);
        logic [7:0] xx;
        logic [6:0] yy;
        logic [2:0] cc;
        xx = px[7:0];
        yy = py[6:0];
        cc = pc[2:0];
        return {xx, yy, cc};
    endfunction

    function automatic int id_colour(input int id);
        case (id)
            0: return 4;
            1: return 2;
            2: return 1;
            default: return 6;
        endcase
    endfunction

    // Model: every pixel of a tile request in raster order.
    task automatic push_tile(input int id, input int loc);
        int ox, oy, c;
        ox = (loc % 2) * 80;
        oy = (loc / 2) * 60;
        for (int cy = 0; cy < 60; cy++)
            for (int cx = 0; cx < 80; cx++) begin
                c = (cx == 0 || cx == 79 || cy == 0 || cy == 59) ? 7 : id_colour(id);
                exp_q.push_back(pix(ox + cx, oy + cy, c));
            end
    endtask

    // Model: every pixel of a full-screen fill.
    task automatic push_fill(input int c);
        for (int cy = 0; cy < 120; cy++)
            for (int cx = 0; cx < 160; cx++)
                exp_q.push_back(pix(cx, cy, c));
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #2;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k;
        k = 0;
        while (n_done == d0 && k < budget) begin
            step(1);
            k++;
        end
        check("done_once", n_done - d0, 1);
    endtask

    // Compare process: drains the expected queue on every plot and checks done placement.
    always @(negedge Clock) begin
        if (Reset) begin
            if (plot) n_raw++;
            if (done) n_done++;
            if (mon_en) begin
                if (want_done || done) begin
                    check("done_after_last", done, want_done);
                    if (want_done) begin
                        check("done_plot_low", plot, 0);
                        check("done_busy_low", busy, 0);
                    end
                end
                want_done = 0;
                if (plot) begin
                    check("busy_while_plot", busy, 1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_plot", plot, 0);
                    end else begin
                        e   = exp_q.pop_front();
                        got = {x, y, colour};
                        check("pixel", got, e);
                        if (op_idx == 0)  cap_first = got;
                        if (op_idx == 81) cap_81 = got;
                        cap_last = got;
                        op_idx++;
                        if (exp_q.size() == 0) begin
                            want_done = 1;
                            op_idx    = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int d0, r0, k;
        Reset = 1'b0; draw = 0; clear = 0; win = 0; tile_id = 0; location = 0;
        repeat (2) @(posedge Clock);
        #1;
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_colour", colour, 0);
        check("rst_plot", plot, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        step(1);
        Reset = 1'b1;
        step(2);

        // Reset in the middle of a tile.
        draw = 1; tile_id = 0; location = 0;
        k = 0;
        while (n_raw < 100 && k < 400) begin
            step(1);
            k++;
        end
        check("reached_pixel_100", n_raw >= 100, 1);
        d0 = n_done;
        draw = 0;
        Reset = 1'b0;
        #1;
        check("async_rst_plot", plot, 0);
        check("async_rst_busy", busy, 0);
        step(1);
        check("rst_edge_plot", plot, 0);
        check("rst_edge_busy", busy, 0);
        check("rst_no_done", n_done - d0, 0);
        Reset = 1'b1;
        step(2);
        mon_en = 1;

        // Clean restart, with acceptance latency pinned.
        push_tile(1, 1);
        d0 = n_done;
        draw = 1; tile_id = 1; location = 1;
        step(1);
        check("busy_after_accept", busy, 1);
        check("no_plot_on_accept", plot, 0);
        step(1);
        check("first_plot_next", plot, 1);
        wait_done(d0, 6000);
        draw = 0;
        check("restart_first", cap_first, pix(80, 0, 7));
        step(3);

        // Tile at slot 3, id 2, draw held after done.
        push_tile(2, 3);
        d0 = n_done;
        draw = 1; tile_id = 2; location = 3;
        wait_done(d0, 6000);
        check("t3_first", cap_first, pix(80, 60, 7));
        check("t3_interior", cap_81, pix(81, 61, 1));
        check("t3_last", cap_last, pix(159, 119, 7));
        r0 = n_raw; d0 = n_done;
        step(200);
        check("held_no_plots", n_raw - r0, 0);
        check("held_no_done", n_done - d0, 0);
        draw = 0;
        step(2);

        // New tile at slot 0; inputs change mid-draw and must be ignored.
        push_tile(3, 0);
        d0 = n_done;
        draw = 1; tile_id = 3; location = 0;
        step(500);
        tile_id = 1; location = 2;
        wait_done(d0, 6000);
        draw = 0;
        check("t0_first", cap_first, pix(0, 0, 7));
        check("t0_interior", cap_81, pix(1, 1, 6));
        check("t0_last", cap_last, pix(79, 59, 7));
        step(3);

        // clear and draw together: clear wins.
        push_fill(0);
        d0 = n_done;
        clear = 1; draw = 1; tile_id = 2; location = 3;
        wait_done(d0, 20000);
        clear = 0; draw = 0;
        check("clr_first", cap_first, pix(0, 0, 0));
        check("clr_81", cap_81, pix(81, 0, 0));
        check("clr_last", cap_last, pix(159, 119, 0));
        step(3);

        // win held: exactly one fill until it toggles.
        push_fill(2);
        d0 = n_done;
        win = 1;
        wait_done(d0, 20000);
        check("win_81", cap_81, pix(81, 0, 2));
        check("win_last", cap_last, pix(159, 119, 2));
        r0 = n_raw; d0 = n_done;
        step(300);
        check("win_no_refill", n_raw - r0, 0);
        check("win_no_extra_done", n_done - d0, 0);
        win = 0;
        step(3);
        push_fill(2);
        d0 = n_done;
        win = 1;
        wait_done(d0, 20000);
        win = 0;
        step(5);

        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
